data_sync_tx: RTL and testbench

- Source-domain transmitter for the multi-flop bus synchronizer.
- Accepts a word from local logic over a valid/ready handshake and holds it on UNSYNC_bus.
- Drives bus_enable under a 4-phase level handshake. The destination returns a level acknowledge (its synchronized copy of bus_enable), which this block synchronizes back into CLK.
- Guarantees UNSYNC_bus is stable for the whole interval in which the destination may sample it.

---
 rtl/data_sync_tx_if.sv | 21 ++
 rtl/data_sync_tx.sv | 85 ++++++++
 tb/tb_data_sync_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_sync_tx_if.sv
// data_sync_tx_if: local valid/ready side, destination request/ack side and status of the source-domain transmitter.
interface data_sync_tx_if #(parameter int BUS_WIDTH = 8);
  logic [BUS_WIDTH-1:0] IN_DATA;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [BUS_WIDTH-1:0] UNSYNC_bus;
  logic                 bus_enable;
  logic                 ACK_async;
  logic                 BUSY;
  logic                 DONE;
  logic                 TIMEOUT_ERR;
  logic                 ERR_CLR;
  modport master (
    input  IN_DATA, IN_VALID, ACK_async, ERR_CLR,
    output IN_READY, UNSYNC_bus, bus_enable, BUSY, DONE, TIMEOUT_ERR
  );
  modport slave (
    output IN_DATA, IN_VALID, ACK_async, ERR_CLR,
    input  IN_READY, UNSYNC_bus, bus_enable, BUSY, DONE, TIMEOUT_ERR
  );
endinterface

// File: rtl/data_sync_tx.sv
// data_sync_tx: source side of a multi-flop bus synchronizer, holds a word and runs a 4-phase level handshake.
module data_sync_tx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int TIMEOUT    = 0
) (
  input logic              CLK,
  input logic              RST_n,
  data_sync_tx_if.master   bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;
  state_t                r_state, w_state;
  logic [NUM_STAGES-1:0] r_ack;
  logic [BUS_WIDTH-1:0]  r_data, w_data;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_en, w_en, r_done, w_done, r_err, w_err, r_fail, w_fail;
  logic                  w_ack_s, w_tmo;
  assign w_ack_s = r_ack[NUM_STAGES-1];
  assign w_tmo   = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ack   <= {r_ack[NUM_STAGES-2:0], bus.ACK_async};
      r_data  <= w_data;
      r_cnt   <= w_cnt;
      r_en    <= w_en;
      r_done  <= w_done;
      r_err   <= w_err;
      r_fail  <= w_fail;
    end
  end
  // a timeout in the same cycle as ERR_CLR must leave the error set, so the set is applied last
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_cnt   = r_cnt;
    w_en    = r_en;
    w_done  = 1'b0;
    w_err   = r_err & ~bus.ERR_CLR;
    w_fail  = r_fail;
    case (r_state)
      IDLE: if (bus.IN_VALID) begin
        w_data  = bus.IN_DATA;
        w_state = SETUP;
      end
      SETUP: begin
        w_en    = 1'b1;
        w_cnt   = '0;
        w_fail  = 1'b0;
        w_state = REQ;
      end
      REQ: if (w_ack_s) begin
        w_en    = 1'b0;
        w_state = REL;
      end else if (w_tmo) begin
        w_en    = 1'b0;
        w_err   = 1'b1;
        w_fail  = 1'b1;
        w_state = REL;
      end else
        w_cnt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      REL: if (!w_ack_s) begin
        w_done  = ~r_fail;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  assign bus.IN_READY    = RST_n && (r_state == IDLE);
  assign bus.BUSY        = (r_state != IDLE);
  assign bus.UNSYNC_bus  = r_data;
  assign bus.bus_enable  = r_en;
  assign bus.DONE        = r_done;
  assign bus.TIMEOUT_ERR = r_err;
endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed scenarios for data_sync_tx with a 3-cycle ack loopback from the destination.
module tb_data_sync_tx;
  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [2:0] r_lb = '0;
  logic       ack_on = 1'b1;
  logic       ack_pulse = 1'b0;
  int         checks = 0;
  int         failures = 0;
  data_sync_tx_if #(.BUS_WIDTH(8)) bus();
  data_sync_tx #(.NUM_STAGES(2), .BUS_WIDTH(8), .TIMEOUT(16)) dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK or negedge RST_n) r_lb <= !RST_n ? 3'b000 : {r_lb[1:0], bus.bus_enable};
  assign bus.ACK_async = (ack_on & r_lb[2]) | ack_pulse;
  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic test_reset;
    bus.IN_DATA = 8'h00;
    bus.IN_VALID = 1'b0;
    bus.ERR_CLR = 1'b0;
    #1;
    checks++;
    if ({bus.UNSYNC_bus, bus.bus_enable, bus.DONE, bus.TIMEOUT_ERR, bus.BUSY} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 000", {bus.UNSYNC_bus, bus.bus_enable, bus.DONE, bus.TIMEOUT_ERR, bus.BUSY});
    end
    @(negedge CLK);
    RST_n = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.IN_READY, bus.BUSY} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: ready/busy got %b expected 10", {bus.IN_READY, bus.BUSY});
    end
  endtask
  task automatic test_single(input logic [7:0] d);
    logic [2:0] exp;
    bus.IN_DATA = d;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_VALID = 1'b0;
    checks++;
    if ({bus.UNSYNC_bus, bus.bus_enable, bus.IN_READY, bus.BUSY} !== {d, 3'b001}) begin
      failures++;
      $display("FAIL single_accept: got %h expected %h", {bus.UNSYNC_bus, bus.bus_enable, bus.IN_READY, bus.BUSY}, {d, 3'b001});
    end
    for (int e = 1; e <= 14; e++) begin
      tick;
      exp = {e <= 6, e == 13, e >= 13};
      checks++;
      if ({bus.bus_enable, bus.DONE, bus.IN_READY} !== exp) begin
        failures++;
        $display("FAIL single_edge%0d: en/done/ready got %b expected %b", e, {bus.bus_enable, bus.DONE, bus.IN_READY}, exp);
      end
      if (e == 11) begin
        #1 ack_pulse = 1'b1;
        #2 ack_pulse = 1'b0;
      end
    end
    checks++;
    if (bus.UNSYNC_bus !== d) begin
      failures++;
      $display("FAIL single_hold: bus got %h expected %h", bus.UNSYNC_bus, d);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] ed;
    logic       ep;
    bus.IN_DATA = 8'h11;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_DATA = 8'h22;
    for (int e = 1; e <= 27; e++) begin
      tick;
      ed = (e >= 14) ? 8'h22 : 8'h11;
      ep = (e == 13) || (e == 27);
      checks++;
      if ({bus.UNSYNC_bus, bus.DONE, bus.IN_READY} !== {ed, ep, ep}) begin
        failures++;
        $display("FAIL b2b_edge%0d: bus/done/ready got %h expected %h", e, {bus.UNSYNC_bus, bus.DONE, bus.IN_READY}, {ed, ep, ep});
      end
      if (e == 15) bus.IN_VALID = 1'b0;
    end
  endtask
  task automatic test_busy_ignore;
    bus.IN_DATA = 8'hA5;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_VALID = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick;
      checks++;
      if (bus.UNSYNC_bus !== 8'hA5) begin
        failures++;
        $display("FAIL busy_hold_edge%0d: bus got %h expected a5", e, bus.UNSYNC_bus);
      end
      if (e == 3) begin
        bus.IN_DATA = 8'hFF;
        bus.IN_VALID = 1'b1;
      end
      if (e == 10) bus.IN_VALID = 1'b0;
    end
    checks++;
    if ({bus.BUSY, bus.IN_READY} !== 2'b01) begin
      failures++;
      $display("FAIL busy_no_extra: busy/ready got %b expected 01", {bus.BUSY, bus.IN_READY});
    end
  endtask
  task automatic test_timeout;
    logic [3:0] exp;
    ack_on = 1'b0;
    bus.IN_DATA = 8'h3C;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_VALID = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      tick;
      exp = {e <= 16, e >= 17, e <= 17, 1'b0};
      checks++;
      if ({bus.bus_enable, bus.TIMEOUT_ERR, bus.BUSY, bus.DONE} !== exp) begin
        failures++;
        $display("FAIL timeout_edge%0d: en/err/busy/done got %b expected %b", e, {bus.bus_enable, bus.TIMEOUT_ERR, bus.BUSY, bus.DONE}, exp);
      end
    end
    bus.ERR_CLR = 1'b1;
    tick;
    bus.ERR_CLR = 1'b0;
    checks++;
    if (bus.TIMEOUT_ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err got %b expected 0", bus.TIMEOUT_ERR);
    end
  endtask
  task automatic test_clr_vs_timeout;
    ack_on = 1'b0;
    bus.IN_DATA = 8'hC3;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_VALID = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      tick;
      if (e == 16) begin
        checks++;
        if ({bus.TIMEOUT_ERR, bus.bus_enable} !== 2'b01) begin
          failures++;
          $display("FAIL clr_pre_edge16: err/en got %b expected 01", {bus.TIMEOUT_ERR, bus.bus_enable});
        end
        bus.ERR_CLR = 1'b1;
      end
      if (e == 17) begin
        bus.ERR_CLR = 1'b0;
        checks++;
        if ({bus.TIMEOUT_ERR, bus.bus_enable} !== 2'b10) begin
          failures++;
          $display("FAIL set_wins_edge17: err/en got %b expected 10", {bus.TIMEOUT_ERR, bus.bus_enable});
        end
      end
    end
    tick;
    tick;
    ack_on = 1'b1;
  endtask
  task automatic test_reset_mid;
    bus.IN_DATA = 8'h77;
    bus.IN_VALID = 1'b1;
    tick;
    bus.IN_VALID = 1'b0;
    for (int e = 1; e <= 4; e++) tick;
    checks++;
    if ({bus.bus_enable, bus.TIMEOUT_ERR, bus.UNSYNC_bus} !== {2'b11, 8'h77}) begin
      failures++;
      $display("FAIL mid_pre: en/err/bus got %h expected 377", {bus.bus_enable, bus.TIMEOUT_ERR, bus.UNSYNC_bus});
    end
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if ({bus.UNSYNC_bus, bus.bus_enable, bus.BUSY, bus.DONE, bus.TIMEOUT_ERR} !== 12'h000) begin
      failures++;
      $display("FAIL mid_async_reset: got %h expected 000", {bus.UNSYNC_bus, bus.bus_enable, bus.BUSY, bus.DONE, bus.TIMEOUT_ERR});
    end
    @(negedge CLK);
    RST_n = 1'b1;
    tick;
    test_single(8'h5A);
  endtask
  initial begin
    test_reset;
    test_single(8'hA5);
    test_back_to_back;
    test_busy_ignore;
    test_timeout;
    test_clr_vs_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
